// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the ALU reservation station.
// slave = the reservation station; master = the surrounding pipeline (decoder, CDB, ALU).
interface alu_rs_if #(
    parameter int CSU_SIZE_BITS = 4
);
    // Dispatch from the decoder
    logic                     dispatch_valid;
    logic [CSU_SIZE_BITS-1:0] dispatch_ins_id;
    logic [6:0]               dispatch_opcode;
    logic [2:0]               dispatch_funct3;
    logic [6:0]               dispatch_funct7;
    logic [31:0]              dispatch_imm;
    logic [5:0]               dispatch_shamt;
    logic [31:0]              dispatch_PC;
    logic                     dispatch_is_compressed;
    logic                     dispatch_rs1_ready;
    logic [31:0]              dispatch_rs1_val;
    logic [CSU_SIZE_BITS-1:0] dispatch_rs1_tag;
    logic                     dispatch_rs2_ready;
    logic [31:0]              dispatch_rs2_val;
    logic [CSU_SIZE_BITS-1:0] dispatch_rs2_tag;

    // Result broadcasts
    logic                     cdb_alu_rdy;
    logic [CSU_SIZE_BITS-1:0] cdb_alu_id;
    logic [31:0]              cdb_alu_res;
    logic                     cdb_mem_rdy;
    logic [CSU_SIZE_BITS-1:0] cdb_mem_id;
    logic [31:0]              cdb_mem_res;

    // Status and issue bundle towards the ALU
    logic                     rs_full;
    logic                     have_ins;
    logic [CSU_SIZE_BITS-1:0] ins_id;
    logic [31:0]              rs1_val;
    logic [31:0]              rs2_val;
    logic [31:0]              imm_val;
    logic [5:0]               shamt_val;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [31:0]              request_PC;
    logic                     is_compressed_ins;

    modport slave (
        input  dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3,
               dispatch_funct7, dispatch_imm, dispatch_shamt, dispatch_PC,
               dispatch_is_compressed, dispatch_rs1_ready, dispatch_rs1_val,
               dispatch_rs1_tag, dispatch_rs2_ready, dispatch_rs2_val, dispatch_rs2_tag,
               cdb_alu_rdy, cdb_alu_id, cdb_alu_res, cdb_mem_rdy, cdb_mem_id, cdb_mem_res,
        output rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
               opcode, funct3, funct7, request_PC, is_compressed_ins
    );

    modport master (
        output dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3,
               dispatch_funct7, dispatch_imm, dispatch_shamt, dispatch_PC,
               dispatch_is_compressed, dispatch_rs1_ready, dispatch_rs1_val,
               dispatch_rs1_tag, dispatch_rs2_ready, dispatch_rs2_val, dispatch_rs2_tag,
               cdb_alu_rdy, cdb_alu_id, cdb_alu_res, cdb_mem_rdy, cdb_mem_id, cdb_mem_res,
        input  rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
               opcode, funct3, funct7, request_PC, is_compressed_ins
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive, issues one per cycle.
// Define ALU_RS_AGE_PRIORITY_EN for oldest-first issue; otherwise lowest-index-first.
module alu_rs #(
    parameter int CSU_SIZE_BITS = 4,
    parameter int RS_SIZE       = 8
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    input  logic    flush_pipline,
    alu_rs_if.slave bus
);
    localparam int IDX_BITS = $clog2(RS_SIZE);

    typedef logic [CSU_SIZE_BITS-1:0] id_t;
    typedef logic [IDX_BITS-1:0]      idx_t;

    // Everything the ALU receives on issue
    typedef struct packed {
        id_t         ins_id;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [5:0]  shamt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] pc;
        logic        is_compressed;
    } issue_t;

    typedef struct packed {
        issue_t op;
        logic   rs1_rdy;
        id_t    rs1_tag;
        logic   rs2_rdy;
        id_t    rs2_tag;
    } entry_t;

    entry_t             entries     [RS_SIZE];
    entry_t             entries_nxt [RS_SIZE];
    entry_t             dispatch_entry;
    logic [RS_SIZE-1:0] valid_q;
    logic [RS_SIZE-1:0] valid_nxt;
    logic [RS_SIZE-1:0] issuable;
    idx_t               free_idx;
    idx_t               issue_idx;
    logic               rs_full;
    logic               issue_en;
    logic               dispatch_en;
    logic               have_ins_q;
    issue_t             issue_q;

    // Capture a broadcast result into any waiting operand; the ALU bus wins a double match.
    function automatic entry_t wake(
        input entry_t      e,
        input logic        a_rdy,
        input id_t         a_id,
        input logic [31:0] a_res,
        input logic        m_rdy,
        input id_t         m_id,
        input logic [31:0] m_res
    );
        entry_t w;
        w = e;
        if (!e.rs1_rdy) begin
            if (a_rdy && e.rs1_tag == a_id) begin
                w.rs1_rdy    = 1'b1;
                w.op.rs1_val = a_res;
            end else if (m_rdy && e.rs1_tag == m_id) begin
                w.rs1_rdy    = 1'b1;
                w.op.rs1_val = m_res;
            end
        end
        if (!e.rs2_rdy) begin
            if (a_rdy && e.rs2_tag == a_id) begin
                w.rs2_rdy    = 1'b1;
                w.op.rs2_val = a_res;
            end else if (m_rdy && e.rs2_tag == m_id) begin
                w.rs2_rdy    = 1'b1;
                w.op.rs2_val = m_res;
            end
        end
        return w;
    endfunction

    assign rs_full     = &valid_q;
    assign dispatch_en = bus.dispatch_valid && !rs_full && !flush_pipline;
    assign issue_en    = (|issuable) && !flush_pipline;

    always_comb begin
        dispatch_entry               = '0;
        dispatch_entry.op.ins_id     = bus.dispatch_ins_id;
        dispatch_entry.op.rs1_val    = bus.dispatch_rs1_val;
        dispatch_entry.op.rs2_val    = bus.dispatch_rs2_val;
        dispatch_entry.op.imm        = bus.dispatch_imm;
        dispatch_entry.op.shamt      = bus.dispatch_shamt;
        dispatch_entry.op.opcode     = bus.dispatch_opcode;
        dispatch_entry.op.funct3     = bus.dispatch_funct3;
        dispatch_entry.op.funct7     = bus.dispatch_funct7;
        dispatch_entry.op.pc         = bus.dispatch_PC;
        dispatch_entry.op.is_compressed = bus.dispatch_is_compressed;
        dispatch_entry.rs1_rdy       = bus.dispatch_rs1_ready;
        dispatch_entry.rs1_tag       = bus.dispatch_rs1_tag;
        dispatch_entry.rs2_rdy       = bus.dispatch_rs2_ready;
        dispatch_entry.rs2_tag       = bus.dispatch_rs2_tag;
    end

    // Lowest-index free slot; unused when the station is full.
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = idx_t'(i);
        end
    end

    always_comb begin
        issuable = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            issuable[i] = valid_q[i] && entries[i].rs1_rdy && entries[i].rs2_rdy;
        end
    end

`ifdef ALU_RS_AGE_PRIORITY_EN
    // older_q[i][j] set means entry j was dispatched before entry i.
    logic [RS_SIZE-1:0] older_q [RS_SIZE];

    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (issuable[i] && ((older_q[i] & issuable) == '0)) issue_idx = idx_t'(i);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
            end else if (dispatch_en) begin
                // A new entry is younger than everything already present.
                for (int i = 0; i < RS_SIZE; i++) older_q[i][free_idx] <= 1'b0;
                older_q[free_idx] <= valid_q;
            end
        end
    end
`else
    always_comb begin
        issue_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (issuable[i]) issue_idx = idx_t'(i);
        end
    end
`endif

    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    always_comb begin
        valid_nxt = valid_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_nxt[i] = wake(entries[i], bus.cdb_alu_rdy, bus.cdb_alu_id, bus.cdb_alu_res,
                                  bus.cdb_mem_rdy, bus.cdb_mem_id, bus.cdb_mem_res);
        end
        if (issue_en) valid_nxt[issue_idx] = 1'b0;
        // Wake the incoming operands too, so a same-cycle broadcast is never lost.
        if (dispatch_en) begin
            entries_nxt[free_idx] = wake(dispatch_entry, bus.cdb_alu_rdy, bus.cdb_alu_id,
                                         bus.cdb_alu_res, bus.cdb_mem_rdy, bus.cdb_mem_id,
                                         bus.cdb_mem_res);
            valid_nxt[free_idx]   = 1'b1;
        end
        if (flush_pipline) valid_nxt = '0;
    end

    // NOTE: entry payload is deliberately not reset; valid_q alone decides whether a slot holds an op.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) entries[i] <= entries_nxt[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q    <= '0;
            have_ins_q <= 1'b0;
            issue_q    <= '0;
        end else if (rdy_in) begin
            valid_q    <= valid_nxt;
            have_ins_q <= issue_en;
            if (issue_en) issue_q <= entries[issue_idx].op;
        end
    end

    assign bus.rs_full           = rs_full;
    assign bus.have_ins          = have_ins_q;
    assign bus.ins_id            = issue_q.ins_id;
    assign bus.rs1_val           = issue_q.rs1_val;
    assign bus.rs2_val           = issue_q.rs2_val;
    assign bus.imm_val           = issue_q.imm;
    assign bus.shamt_val         = issue_q.shamt;
    assign bus.opcode            = issue_q.opcode;
    assign bus.funct3            = issue_q.funct3;
    assign bus.funct7            = issue_q.funct7;
    assign bus.request_PC        = issue_q.pc;
    assign bus.is_compressed_ins = issue_q.is_compressed;
endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed dispatch/broadcast vectors, monitor checks every issue.
// Issue-order expectations follow ALU_RS_AGE_PRIORITY_EN when it is defined.
module tb_alu_rs;
    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic flush_pipline;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    alu_rs_if #(.CSU_SIZE_BITS(4)) bus ();

    alu_rs #(.CSU_SIZE_BITS(4), .RS_SIZE(8)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .bus           (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm);
        exp_t e;
        e.id  = id;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.imm = imm;
        exp_q.push_back(e);
    endtask

    // Side fields are derived from the id so the monitor can predict them.
    task automatic dispatch(input logic [3:0] id,
                            input logic r1_rdy, input logic [31:0] r1, input logic [3:0] t1,
                            input logic r2_rdy, input logic [31:0] r2, input logic [3:0] t2,
                            input logic [31:0] imm);
        bus.dispatch_valid         = 1'b1;
        bus.dispatch_ins_id        = id;
        bus.dispatch_opcode        = 7'h13;
        bus.dispatch_funct3        = id[2:0];
        bus.dispatch_funct7        = {3'b000, id};
        bus.dispatch_imm           = imm;
        bus.dispatch_shamt         = {2'b00, id};
        bus.dispatch_PC            = 32'h1000 + (32'(id) << 2);
        bus.dispatch_is_compressed = id[0];
        bus.dispatch_rs1_ready     = r1_rdy;
        bus.dispatch_rs1_val       = r1;
        bus.dispatch_rs1_tag       = t1;
        bus.dispatch_rs2_ready     = r2_rdy;
        bus.dispatch_rs2_val       = r2;
        bus.dispatch_rs2_tag       = t2;
        step();
        bus.dispatch_valid         = 1'b0;
    endtask

    task automatic alu_cast(input logic [3:0] id, input logic [31:0] res);
        bus.cdb_alu_rdy = 1'b1;
        bus.cdb_alu_id  = id;
        bus.cdb_alu_res = res;
        step();
        bus.cdb_alu_rdy = 1'b0;
    endtask

    // Monitor: every issued bundle must match the head of the scoreboard.
    always @(negedge clk_in) begin
        if (bus.have_ins === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'(bus.have_ins), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_id", 64'(bus.ins_id), 64'(mon_e.id));
                check("issue_rs1", 64'(bus.rs1_val), 64'(mon_e.rs1));
                check("issue_rs2", 64'(bus.rs2_val), 64'(mon_e.rs2));
                check("issue_imm", 64'(bus.imm_val), 64'(mon_e.imm));
                check("issue_fields",
                      64'({bus.opcode, bus.funct3, bus.funct7, bus.shamt_val, bus.request_PC,
                           bus.is_compressed_ins}),
                      64'({7'h13, mon_e.id[2:0], {3'b000, mon_e.id}, {2'b00, mon_e.id},
                           32'h1000 + (32'(mon_e.id) << 2), mon_e.id[0]}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "time limit");
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush_pipline = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_ins_id = '0;
        bus.dispatch_opcode = '0;
        bus.dispatch_funct3 = '0;
        bus.dispatch_funct7 = '0;
        bus.dispatch_imm = '0;
        bus.dispatch_shamt = '0;
        bus.dispatch_PC = '0;
        bus.dispatch_is_compressed = 1'b0;
        bus.dispatch_rs1_ready = 1'b0;
        bus.dispatch_rs1_val = '0;
        bus.dispatch_rs1_tag = '0;
        bus.dispatch_rs2_ready = 1'b0;
        bus.dispatch_rs2_val = '0;
        bus.dispatch_rs2_tag = '0;
        bus.cdb_alu_rdy = 1'b0;
        bus.cdb_alu_id = '0;
        bus.cdb_alu_res = '0;
        bus.cdb_mem_rdy = 1'b0;
        bus.cdb_mem_id = '0;
        bus.cdb_mem_res = '0;
        repeat (2) step();
        rst_in = 1'b0;
        check("reset_have_ins", 64'(bus.have_ins), 64'd0);
        check("reset_rs_full", 64'(bus.rs_full), 64'd0);
        check("reset_ins_id", 64'(bus.ins_id), 64'd0);
        check("reset_rs1_val", 64'(bus.rs1_val), 64'd0);

        // Ready ADDI: issues exactly one edge after dispatch, for one cycle.
        push(4'd3, 32'h11, 32'h0, 32'h5);
        dispatch(4'd3, 1'b1, 32'h11, 4'd0, 1'b1, 32'h0, 4'd0, 32'h5);
        check("lat_before", 64'(bus.have_ins), 64'd0);
        step();
        check("lat_issue", 64'(bus.have_ins), 64'd1);
        step();
        check("lat_after", 64'(bus.have_ins), 64'd0);

        // rs1 waits on tag 2, woken by the ALU broadcast.
        push(4'd5, 32'h1234, 32'h22, 32'h7);
        dispatch(4'd5, 1'b0, 32'h0, 4'd2, 1'b1, 32'h22, 4'd0, 32'h7);
        step();
        alu_cast(4'd2, 32'h1234);
        check("wake_before", 64'(bus.have_ins), 64'd0);
        step();
        check("wake_issue", 64'(bus.have_ins), 64'd1);

        // Dispatch racing a memory broadcast for its rs2 tag.
        push(4'd6, 32'h33, 32'hBEEF, 32'h9);
        bus.cdb_mem_rdy = 1'b1;
        bus.cdb_mem_id  = 4'd7;
        bus.cdb_mem_res = 32'hBEEF;
        dispatch(4'd6, 1'b1, 32'h33, 4'd0, 1'b0, 32'h0, 4'd7, 32'h9);
        bus.cdb_mem_rdy = 1'b0;
        step();
        check("race_issue", 64'(bus.have_ins), 64'd1);

        // Both buses match the same tag at dispatch: ALU value wins.
        push(4'd4, 32'hAAAA, 32'h44, 32'h1);
        bus.cdb_alu_rdy = 1'b1;
        bus.cdb_alu_id  = 4'd9;
        bus.cdb_alu_res = 32'hAAAA;
        bus.cdb_mem_rdy = 1'b1;
        bus.cdb_mem_id  = 4'd9;
        bus.cdb_mem_res = 32'hBBBB;
        dispatch(4'd4, 1'b0, 32'h0, 4'd9, 1'b1, 32'h44, 4'd0, 32'h1);
        bus.cdb_alu_rdy = 1'b0;
        bus.cdb_mem_rdy = 1'b0;
        repeat (2) step();

        // rdy_in low: the broadcast and the dispatch in that cycle are both dropped.
        dispatch(4'd8, 1'b0, 32'h0, 4'd10, 1'b1, 32'h0, 4'd0, 32'h2);
        rdy_in = 1'b0;
        bus.cdb_alu_rdy = 1'b1;
        bus.cdb_alu_id  = 4'd10;
        bus.cdb_alu_res = 32'h5555;
        dispatch(4'd9, 1'b1, 32'h99, 4'd0, 1'b1, 32'h0, 4'd0, 32'h3);
        rdy_in = 1'b1;
        bus.cdb_alu_rdy = 1'b0;
        repeat (3) step();
        check("freeze_no_issue", 64'(bus.have_ins), 64'd0);
        push(4'd8, 32'h6666, 32'h0, 32'h2);
        alu_cast(4'd10, 32'h6666);
        step();
        check("freeze_wake_issue", 64'(bus.have_ins), 64'd1);
        step();

        // Fill all eight slots with blocked ops; the ninth dispatch is refused.
        for (int i = 0; i < 8; i++) begin
            dispatch(4'(i), 1'b0, 32'h0, 4'(i + 8), 1'b1, 32'h300 + 32'(i), 4'd0, 32'h10);
        end
        check("full_set", 64'(bus.rs_full), 64'd1);
        dispatch(4'd8, 1'b1, 32'h77, 4'd0, 1'b1, 32'h0, 4'd0, 32'h4);
        check("full_refuse", 64'(bus.rs_full), 64'd1);
        push(4'd0, 32'h100, 32'h300, 32'h10);
        alu_cast(4'd8, 32'h100);
        check("full_woken", 64'(bus.rs_full), 64'd1);
        step();
        check("full_issue", 64'(bus.have_ins), 64'd1);
        check("full_cleared", 64'(bus.rs_full), 64'd0);

        // Flush with seven pending ops and a racing dispatch; none may issue afterwards.
        flush_pipline = 1'b1;
        dispatch(4'd9, 1'b1, 32'h55, 4'd0, 1'b1, 32'h0, 4'd0, 32'h6);
        flush_pipline = 1'b0;
        check("flush_rs_full", 64'(bus.rs_full), 64'd0);
        check("flush_have_ins", 64'(bus.have_ins), 64'd0);
        for (int t = 9; t < 16; t++) alu_cast(4'(t), 32'hDEAD);
        repeat (2) step();

        // Age order: id 1 in slot 3 is older than id 2 later placed in slot 0.
        push(4'd10, 32'h4040, 32'h0, 32'h0);
        dispatch(4'd10, 1'b0, 32'h0, 4'd4, 1'b1, 32'h0, 4'd0, 32'h0);
        dispatch(4'd11, 1'b0, 32'h0, 4'd5, 1'b1, 32'h0, 4'd0, 32'h0);
        dispatch(4'd13, 1'b0, 32'h0, 4'd5, 1'b1, 32'h0, 4'd0, 32'h0);
        dispatch(4'd1, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0, 32'h0);
        alu_cast(4'd4, 32'h4040);
        step();
        dispatch(4'd2, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0, 32'h0);
`ifdef ALU_RS_AGE_PRIORITY_EN
        push(4'd1, 32'h9999, 32'h0, 32'h0);
        push(4'd2, 32'h9999, 32'h0, 32'h0);
`else
        push(4'd2, 32'h9999, 32'h0, 32'h0);
        push(4'd1, 32'h9999, 32'h0, 32'h0);
`endif
        alu_cast(4'd9, 32'h9999);
        step();
        check("age_first", 64'(bus.have_ins), 64'd1);
        step();
        check("age_second", 64'(bus.have_ins), 64'd1);
        push(4'd11, 32'h5151, 32'h0, 32'h0);
        push(4'd13, 32'h5151, 32'h0, 32'h0);
        bus.cdb_mem_rdy = 1'b1;
        bus.cdb_mem_id  = 4'd5;
        bus.cdb_mem_res = 32'h5151;
        step();
        bus.cdb_mem_rdy = 1'b0;
        repeat (3) step();

        // Reset mid-operation drops a pending op and clears the bundle.
        dispatch(4'd14, 1'b0, 32'h0, 4'd3, 1'b1, 32'h0, 4'd0, 32'h0);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("midrst_have_ins", 64'(bus.have_ins), 64'd0);
        check("midrst_rs_full", 64'(bus.rs_full), 64'd0);
        check("midrst_ins_id", 64'(bus.ins_id), 64'd0);
        alu_cast(4'd3, 32'h3333);
        repeat (3) step();

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
